sr04_echo_emulator: RTL and testbench

//  Synthesizable HC-SR04 sensor model: the responder end of the trig/echo ultrasonic protocol.

---
 rtl/sr04_echo_emulator.sv | 183 ++++++++++++++++++
 tb/tb_sr04_echo_emulator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sr04_echo_emulator.sv
// HC-SR04 responder model: answers a trig pulse with an echo pulse whose width
// encodes dist_cm. All timing runs off a 1-tick prescaler that restarts on
// every state entry, so intervals are exact multiples of CLK_HZ/TICK_HZ.
// Optional feature macro: SR04_EMU_JITTER_EN adds -4..+3 us LFSR jitter to the
// echo width (clamped to >= 1 us).
module sr04_echo_emulator #(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned TICK_HZ       = 1_000_000,
    parameter int unsigned TRIG_MIN_US   = 10,
    parameter int unsigned ECHO_DELAY_US = 250,
    parameter int unsigned US_PER_CM     = 58,
    parameter int unsigned MAX_CM        = 400,
    parameter int unsigned TIMEOUT_US    = 38000,
    parameter int unsigned HOLDOFF_US    = 60000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [9:0] dist_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_err
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [16:0] TrigMin   = 17'(TRIG_MIN_US);
    localparam logic [16:0] EchoDelay = 17'(ECHO_DELAY_US);
    localparam logic [16:0] UsPerCm   = 17'(US_PER_CM);
    localparam logic [16:0] Timeout   = 17'(TIMEOUT_US);
    localparam logic [16:0] Holdoff   = 17'(HOLDOFF_US);
    localparam logic [9:0]  MaxCm     = 10'(MAX_CM);

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StBurst,
        StEcho,
        StHoldoff
    } state_t;

    state_t      state_q, state_d;
    logic        trig_s1, trig_s2, trig_s3;
    logic        trig_rise, trig_fall;
    logic [PW-1:0] presc_q;
    logic        tick, presc_clr;
    logic [16:0] us_cnt_q, us_cnt_d, us_inc, us_tick;
    logic [9:0]  cm_q, cm_d;
    logic        err_q, err_d;
    logic [16:0] w_base, w;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_s3 <= 1'b0;
        end else begin
            trig_s1 <= trig;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;
        end
    end

    assign trig_rise = trig_s2 & ~trig_s3;
    assign trig_fall = ~trig_s2 & trig_s3;

    assign tick = (presc_q == PW'(DIV - 1));

    // Prescaler: wraps every DIV clocks, restarts when entering a timed state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else if (presc_clr || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Saturating microsecond count including a tick landing in this cycle.
    assign us_inc  = (us_cnt_q == '1) ? us_cnt_q : us_cnt_q + 17'd1;
    assign us_tick = tick ? us_inc : us_cnt_q;

    assign w_base = (cm_q != 10'd0 && cm_q <= MaxCm) ? (17'(cm_q) * UsPerCm) : Timeout;

`ifdef SR04_EMU_JITTER_EN
    logic [7:0]  lfsr_q;
    logic [17:0] w_sum;

    // LFSR x^8+x^6+x^5+x^4+1 steps once per accepted trig.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 8'hA5;
        end else if (state_q == StTrig && state_d == StBurst) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // Jittered width: base + lfsr[2:0] - 4, never below 1 us.
    always_comb begin
        w_sum = {1'b0, w_base} + 18'(lfsr_q[2:0]);
        if (w_sum <= 18'd4) begin
            w = 17'd1;
        end else begin
            w = 17'(w_sum - 18'd4);
        end
    end
`else
    assign w = w_base;
`endif

    // Next-state logic; any state change restarts the us counter.
    always_comb begin
        state_d   = state_q;
        us_cnt_d  = us_tick;
        cm_d      = cm_q;
        err_d     = 1'b0;
        presc_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                us_cnt_d = '0;
                if (trig_rise) begin
                    state_d = StTrig;
                end
            end
            StTrig: begin
                if (trig_fall) begin
                    if (us_tick >= TrigMin) begin
                        cm_d    = dist_cm;
                        state_d = StBurst;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StBurst: begin
                if (tick && us_inc >= EchoDelay) begin
                    state_d = StEcho;
                end
            end
            StEcho: begin
                if (tick && us_inc >= w) begin
                    state_d = StHoldoff;
                end
            end
            StHoldoff: begin
                if (tick && us_inc >= Holdoff) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (state_d != state_q) begin
            us_cnt_d  = '0;
            presc_clr = (state_d != StIdle);
        end
    end

    // State, counter, latched distance and error pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            us_cnt_q <= '0;
            cm_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            us_cnt_q <= us_cnt_d;
            cm_q     <= cm_d;
            err_q    <= err_d;
        end
    end

    assign echo     = (state_q == StEcho);
    assign busy     = (state_q != StIdle);
    assign trig_err = err_q;

endmodule

// File: tb/tb_sr04_echo_emulator.sv
// Directed bench for sr04_echo_emulator with shrunk timing: 4 clocks per us,
// 5 us burst delay, 2 us per cm, 1000 us timeout, 100 us holdoff.
module tb_sr04_echo_emulator;

    localparam int DIV     = 4;
    localparam int DELAY   = 5;
    localparam int PER_CM  = 2;
    localparam int TMO     = 1000;
    localparam int HOLD    = 100;
    localparam int LAT     = 3 + DELAY * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [9:0] dist_cm;
    logic       echo;
    logic       busy;
    logic       trig_err;

    sr04_echo_emulator #(
        .CLK_HZ       (4),
        .TICK_HZ      (1),
        .TRIG_MIN_US  (10),
        .ECHO_DELAY_US(DELAY),
        .US_PER_CM    (PER_CM),
        .MAX_CM       (400),
        .TIMEOUT_US   (TMO),
        .HOLDOFF_US   (HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .trig    (trig),
        .dist_cm (dist_cm),
        .echo    (echo),
        .busy    (busy),
        .trig_err(trig_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge.
    int   rise_cyc = 0, fall_cyc = 0, idle_cyc = 0, err_cyc = 0;
    int   n_rises = 0, n_err = 0, busy_bad = 0;
    logic echo_p = 1'b0, busy_p = 1'b0, err_p = 1'b0;
    always @(negedge clk) begin
        if (echo && !echo_p) begin
            rise_cyc = cyc;
            n_rises++;
        end
        if (!echo && echo_p) fall_cyc = cyc;
        if (!busy && busy_p) idle_cyc = cyc;
        if (trig_err) begin
            n_err++;
            if (!err_p) err_cyc = cyc;
        end
        if (echo && !busy) busy_bad++;
        echo_p = echo;
        busy_p = busy;
        err_p  = trig_err;
    end

    int n_checks = 0;
    int n_errors = 0;
    int fall_at  = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse(input int hi);
        @(negedge clk);
        trig = 1'b1;
        repeat (hi) @(negedge clk);
        trig = 1'b0;
        fall_at = cyc;
    endtask

    // which: 0 = echo, 1 = busy
    task automatic wait_sig(input string tag, input int which, input logic lvl, input int bound);
        int   n;
        logic v;
        for (n = 0; n < bound; n++) begin
            @(negedge clk);
            v = (which == 0) ? echo : busy;
            if (v == lvl) break;
        end
        #1;
        check_eq(tag, (n < bound) ? 1 : 0, 1);
    endtask

    int r0, e0;
    int dists  [4] = '{0, 500, 400, 1};
    int widths [4] = '{TMO * DIV, TMO * DIV, 400 * PER_CM * DIV, 1 * PER_CM * DIV};
    int shorts [2] = '{20, 36};

    initial begin
        rst = 1'b0;
        trig = 1'b0;
        dist_cm = 10'd0;
        #12;
        check_eq("rst_echo", int'(echo), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_err", int'(trig_err), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Nominal 10 cm, 10 us trig (minimum accepted width)
        dist_cm = 10'd10;
        r0 = n_rises;
        pulse(10 * DIV);
        wait_sig("t1_idle", 1, 1'b0, 5000);
        check_eq("t1_rises", n_rises - r0, 1);
        check_eq("t1_latency", rise_cyc - fall_at, LAT);
        check_eq("t1_width", fall_cyc - rise_cyc, 10 * PER_CM * DIV);
        check_eq("t1_holdoff", idle_cyc - fall_cyc, HOLD * DIV);
        check_eq("t1_busy", busy_bad, 0);

        // Short trig pulses: 5 us and 9 us are both rejected
        foreach (shorts[i]) begin
            r0 = n_rises;
            e0 = n_err;
            pulse(shorts[i]);
            repeat (60) @(negedge clk);
            #1;
            check_eq($sformatf("t2_err_cnt_%0d", i), n_err - e0, 1);
            check_eq($sformatf("t2_err_lat_%0d", i), err_cyc - fall_at, 3);
            check_eq($sformatf("t2_no_echo_%0d", i), n_rises - r0, 0);
            check_eq($sformatf("t2_busy_%0d", i), int'(busy), 0);
        end

        // Range boundaries: 0 and 500 time out, 400 and 1 are in range
        foreach (dists[i]) begin
            dist_cm = 10'(dists[i]);
            pulse(10 * DIV);
            wait_sig($sformatf("t3_idle_%0d", i), 1, 1'b0, 20000);
            check_eq($sformatf("t3_width_%0d", dists[i]), fall_cyc - rise_cyc, widths[i]);
        end

        // Trigs during ECHO and HOLDOFF are ignored
        dist_cm = 10'd100;
        r0 = n_rises;
        e0 = n_err;
        pulse(10 * DIV);
        wait_sig("t4_rise", 0, 1'b1, 200);
        repeat (100) @(negedge clk);
        pulse(12 * DIV);
        wait_sig("t4_fall", 0, 1'b0, 2000);
        repeat (100) @(negedge clk);
        pulse(12 * DIV);
        wait_sig("t4_idle", 1, 1'b0, 2000);
        check_eq("t4_rises", n_rises - r0, 1);
        check_eq("t4_width", fall_cyc - rise_cyc, 100 * PER_CM * DIV);
        check_eq("t4_holdoff", idle_cyc - fall_cyc, HOLD * DIV);
        check_eq("t4_no_err", n_err - e0, 0);
        pulse(10 * DIV);
        wait_sig("t4_idle2", 1, 1'b0, 3000);
        check_eq("t4_rises2", n_rises - r0, 2);
        check_eq("t4_width2", fall_cyc - rise_cyc, 100 * PER_CM * DIV);

        // Asynchronous reset mid-echo, then a normal cycle
        dist_cm = 10'd10;
        pulse(10 * DIV);
        wait_sig("t5_rise", 0, 1'b1, 200);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("t5_echo", int'(echo), 0);
        check_eq("t5_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        pulse(10 * DIV);
        wait_sig("t5_idle", 1, 1'b0, 3000);
        check_eq("t5_latency", rise_cyc - fall_at, LAT);
        check_eq("t5_width", fall_cyc - rise_cyc, 10 * PER_CM * DIV);

        // dist_cm change during BURST does not affect width
        dist_cm = 10'd10;
        pulse(10 * DIV);
        repeat (5) @(negedge clk);
        dist_cm = 10'd20;
        wait_sig("t6_idle", 1, 1'b0, 3000);
        check_eq("t6_latency", rise_cyc - fall_at, LAT);
        check_eq("t6_width", fall_cyc - rise_cyc, 10 * PER_CM * DIV);
        check_eq("t6_busy", busy_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
